i2c_slave_if: RTL

- I2C target (responder) for the i2c_mast initiator; gives the FPGA build a loop-back partner and lets the bench close the bus.
- Oversamples SCL/SDA on the system clock and matches a 7-bit address.
- Write transfers: captures up to 4 data bytes into a 32-bit word.
- Read transfers: returns a 32-bit word MSB-first.
- Open-drain SDA only; no clock stretching.

---
 rtl/i2c_slave_if.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: I2C target with 7-bit address match, up to 4-byte write capture and 32-bit read-back.
// Build option: define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter after each synchroniser.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | driving ACK for the address byte
// WR_BYTE   | shifting in a write data byte
// WR_ACK    | driving ACK for a stored write byte
// RD_BYTE   | driving a read byte MSB-first
// RD_ACK    | SDA released, sampling the master's ACK/NACK
// WAIT_STOP | not addressed or transfer ended, waiting for STOP/START
`timescale 1ns/1ps
module i2c_slave_if #(
  parameter logic [6:0] SLAVE_ADDR = 7'h57,
  parameter int         MAX_BYTES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic [2:0]  rx_count,
  output logic        rx_valid,
  output logic        busy,
  output logic        addr_hit
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_BYTES);

  state_t      state, state_nxt;
  logic        sda_oe, sda_oe_nxt;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_filt, sda_filt;
  logic        scl_q, scl_q_d, sda_q, sda_q_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  shift_reg;
  logic [3:0]  bit_cnt;
  logic [2:0]  wr_cnt;
  logic        wr_pending;
  logic [31:0] tx_snap;
  logic [1:0]  byte_idx;
  logic        mst_ack;
  logic [7:0]  cur_byte, nxt_byte;
  logic        byte_done, addr_match;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      scl_q_d  <= 1'b1;
      sda_q    <= 1'b1;
      sda_q_d  <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda};
      scl_q    <= scl_filt;
      scl_q_d  <= scl_q;
      sda_q    <= sda_filt;
      sda_q_d  <= sda_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  // Two of the last three synchronised samples must agree, so a 1-clk pulse never wins.
  assign scl_filt = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
  assign sda_filt = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
    end
  end
`else
  assign scl_filt = scl_sync[1];
  assign sda_filt = sda_sync[1];
`endif

  assign scl_rise   = scl_q & ~scl_q_d;
  assign scl_fall   = ~scl_q & scl_q_d;
  assign start_det  = scl_q & scl_q_d & sda_q_d & ~sda_q;
  assign stop_det   = scl_q & scl_q_d & ~sda_q_d & sda_q;
  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (shift_reg[7:1] == SLAVE_ADDR);
  assign cur_byte   = byte_sel(tx_snap, byte_idx);
  assign nxt_byte   = byte_sel(tx_snap, byte_idx + 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
    end else begin
      state  <= state_nxt;
      sda_oe <= sda_oe_nxt;
    end
  end

  // SDA only ever changes on the cycle after an SCL falling event.
  always_comb begin
    state_nxt  = state;
    sda_oe_nxt = sda_oe;
    if (start_det) begin
      state_nxt  = ADDR;
      sda_oe_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: sda_oe_nxt = 1'b0;
        ADDR:
          if (scl_fall && byte_done) begin
            if (addr_match) begin
              state_nxt  = ADDR_ACK;
              sda_oe_nxt = 1'b1;
            end else begin
              state_nxt  = WAIT_STOP;
              sda_oe_nxt = 1'b0;
            end
          end
        ADDR_ACK:
          if (scl_fall) begin
            if (shift_reg[0]) begin
              state_nxt  = RD_BYTE;
              sda_oe_nxt = ~tx_snap[31];
            end else begin
              state_nxt  = WR_BYTE;
              sda_oe_nxt = 1'b0;
            end
          end
        WR_BYTE:
          if (scl_fall && byte_done) begin
            if (wr_cnt < MAX_CNT) begin
              state_nxt  = WR_ACK;
              sda_oe_nxt = 1'b1;
            end else begin
              state_nxt  = WAIT_STOP;
              sda_oe_nxt = 1'b0;
            end
          end
        WR_ACK:
          if (scl_fall) begin
            state_nxt  = WR_BYTE;
            sda_oe_nxt = 1'b0;
          end
        RD_BYTE:
          if (scl_fall) begin
            if (byte_done) begin
              state_nxt  = RD_ACK;
              sda_oe_nxt = 1'b0;
            end else begin
              sda_oe_nxt = ~cur_byte[3'd7 - bit_cnt[2:0]];
            end
          end
        RD_ACK:
          if (scl_fall) begin
            if (mst_ack) begin
              state_nxt  = RD_BYTE;
              sda_oe_nxt = ~nxt_byte[7];
            end else begin
              state_nxt  = WAIT_STOP;
              sda_oe_nxt = 1'b0;
            end
          end
        default: sda_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= 8'h00;
      bit_cnt    <= 4'd0;
      wr_cnt     <= 3'd0;
      wr_pending <= 1'b0;
      tx_snap    <= 32'h0;
      byte_idx   <= 2'd0;
      mst_ack    <= 1'b0;
      rx_data    <= 32'h0;
      rx_count   <= 3'd0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      addr_hit   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_det || stop_det) begin
        rx_valid   <= wr_pending;
        wr_pending <= 1'b0;
        addr_hit   <= 1'b0;
        busy       <= start_det;
        bit_cnt    <= 4'd0;
      end else begin
        if (scl_rise && (state == ADDR || state == WR_BYTE)) begin
          shift_reg <= {shift_reg[6:0], sda_q};
          bit_cnt   <= bit_cnt + 4'd1;
        end
        if (scl_rise && state == RD_BYTE)
          bit_cnt <= bit_cnt + 4'd1;
        if (scl_rise && state == RD_ACK)
          mst_ack <= ~sda_q;
        if (state == ADDR && state_nxt == ADDR_ACK) begin
          addr_hit <= 1'b1;
          wr_cnt   <= 3'd0;
          byte_idx <= 2'd0;
          if (shift_reg[0])
            tx_snap <= tx_data;
        end
        if (state == WR_BYTE && state_nxt == WR_ACK) begin
          case (wr_cnt)
            3'd0:    rx_data <= {shift_reg, 24'h0};
            3'd1:    rx_data[23:16] <= shift_reg;
            3'd2:    rx_data[15:8]  <= shift_reg;
            default: rx_data[7:0]   <= shift_reg;
          endcase
          rx_count   <= wr_cnt + 3'd1;
          wr_cnt     <= wr_cnt + 3'd1;
          wr_pending <= 1'b1;
        end
        if (state == RD_ACK && state_nxt == RD_BYTE)
          byte_idx <= byte_idx + 2'd1;
        if (state_nxt != state)
          bit_cnt <= 4'd0;
      end
    end
  end

endmodule
